// File: rtl/alu_seq_pkg.sv
// Shared types for the byte-serial ALU: FSM states, flag bundle,
// ALU op codes and the BCD nibble-adjust helper.
package alu_seq_pkg;

    localparam logic [2:0] ALU_OR  = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_ADD = 3'd3;
    localparam logic [2:0] ALU_SR  = 3'd4;
    localparam logic [2:0] ALU_SL  = 3'd5;
    localparam logic [2:0] ALU_BIT = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } flags_t;

    // Decimal adjust of one raw nibble sum s (5 bits incl. carry).
    // Returns {decimal carry, adjusted nibble}. For subtract the
    // carry means "no borrow"; a borrow needs a -6 correction.
    function automatic logic [4:0] nib_adj(input logic sub,
                                           input logic [4:0] s);
        logic       c;
        logic [3:0] n;
        if (sub) begin
            c = s[4];
            n = c ? s[3:0] : s[3:0] - 4'd6;
        end else begin
            c = (s > 5'd9);
            n = c ? s[3:0] + 4'd6 : s[3:0];
        end
        return {c, n};
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the byte-serial ALU.
// master: requester drives operands + out_ready; slave: the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             sub;
    logic             dec;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             N;
    logic             V;
    logic             Z;
    logic             C;

    modport master (
        output in_valid, op, sub, dec, ai, bi, ci, out_ready,
        input  in_ready, out_valid, out, N, V, Z, C
    );

    modport slave (
        input  in_valid, op, sub, dec, ai, bi, ci, out_ready,
        output in_ready, out_valid, out, N, V, Z, C
    );
endinterface

// File: rtl/alu_seq_slice.sv
// Combinational 8-bit ALU slice. Ports: i_op/i_sub/i_dec select the
// function, i_a/i_b/i_cin operands, o_y result, o_cout carry, o_bmsb = b'[7].
module alu_seq_slice
    import alu_seq_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_sub,
    input  logic       i_dec,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_y,
    output logic       o_cout,
    output logic       o_bmsb
);

    logic [7:0] w_bp;
    logic [7:0] w_aorb;
    logic [4:0] w_lo;
    logic [4:0] w_lo_adj;
    logic [4:0] w_hi;
    logic [4:0] w_hi_adj;
    logic [8:0] w_sum;

    assign w_bp   = i_sub ? ~i_b : i_b;
    assign w_aorb = i_a | i_b;
    assign o_bmsb = w_bp[7];

    always_comb begin
        w_lo     = {1'b0, i_a[3:0]} + {1'b0, w_bp[3:0]} + {4'd0, i_cin};
        w_lo_adj = nib_adj(i_sub, w_lo);
        w_hi     = {1'b0, i_a[7:4]} + {1'b0, w_bp[7:4]}
                 + {4'd0, w_lo_adj[4]};
        w_hi_adj = nib_adj(i_sub, w_hi);
        w_sum    = {1'b0, i_a} + {1'b0, w_bp} + {8'd0, i_cin};
    end

    always_comb begin
        o_y    = 8'd0;
        o_cout = i_cin;
        unique case (i_op)
            ALU_OR:  o_y = i_a | i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_BIT: o_y = i_a & i_b;
            ALU_SL: begin
                o_y    = {w_aorb[6:0], i_cin};
                o_cout = w_aorb[7];
            end
            ALU_SR: begin
                o_y    = {i_cin, w_aorb[7:1]};
                o_cout = w_aorb[0];
            end
            ALU_ADD: begin
                if (i_dec) begin
                    o_y    = {w_hi_adj[3:0], w_lo_adj[3:0]};
                    o_cout = w_hi_adj[4];
                end else begin
                    o_y    = w_sum[7:0];
                    o_cout = w_sum[8];
                end
            end
            default: begin
                o_y    = 8'd0;
                o_cout = i_cin;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Byte-serial multi-byte ALU with BCD add/sub and valid/ready handshakes.
// Ports: clk, rst (sync, active-high), bus (alu_seq_if.slave).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int BYTES      = 2,
    parameter bit DECIMAL_EN = 1
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    localparam int WIDTH = 8 * BYTES;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_t           r_state;
    state_t           w_state_nx;
    logic [2:0]       r_op;
    logic             r_sub;
    logic             r_dec;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_bhi;
    logic             r_carry;
    logic             r_nz;
    logic [IW-1:0]    r_idx;
    flags_t           r_flags;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_shr;
    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;
    logic [7:0]       w_y;
    logic             w_cout;
    logic             w_bmsb;
    logic [WIDTH-1:0] w_acc_nx;
    flags_t           w_flags;

    assign w_in_ready = (r_state == S_IDLE)
                      | ((r_state == S_DONE) & bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_last     = (r_idx == IW'(BYTES - 1));

    // SR walks MSB->LSB so the shift-in bit enters the top byte first.
    assign w_shr    = (r_op == ALU_SR);
    assign w_a_byte = w_shr ? r_a[WIDTH-1 -: 8] : r_a[7:0];
    assign w_b_byte = w_shr ? r_b[WIDTH-1 -: 8] : r_b[7:0];

    alu_seq_slice u_slice (
        .i_op   (r_op),
        .i_sub  (r_sub),
        .i_dec  (r_dec),
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_y    (w_y),
        .o_cout (w_cout),
        .o_bmsb (w_bmsb)
    );

    assign w_acc_nx = w_shr
        ? ((r_acc << 8) | WIDTH'(w_y))
        : ((r_acc >> 8) | (WIDTH'(w_y) << (WIDTH - 8)));

    // Final flags, valid on the last slice. For ADD the last slice is
    // the MSB slice, so its a/b'/y msbs give the overflow.
    always_comb begin
        w_flags   = '0;
        w_flags.n = w_acc_nx[WIDTH-1];
        w_flags.z = ~(r_nz | (|w_y));
        unique case (r_op)
            ALU_ADD: begin
                w_flags.c = w_cout;
                w_flags.v = (w_a_byte[7] ^ w_y[7]) & (w_bmsb ^ w_y[7]);
            end
            ALU_SL, ALU_SR: w_flags.c = w_cout;
            ALU_BIT: begin
                w_flags.n = r_bhi[1];
                w_flags.v = r_bhi[0];
            end
            default: begin
                w_flags.c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_nx = S_RUN;
            S_RUN:  if (w_last)   w_state_nx = S_DONE;
            S_DONE: begin
                if (bus.out_ready)
                    w_state_nx = w_accept ? S_RUN : S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_sub   <= 1'b0;
            r_dec   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_bhi   <= '0;
            r_carry <= 1'b0;
            r_nz    <= 1'b0;
            r_idx   <= '0;
            r_flags <= '0;
        end else if (w_accept) begin
            r_op    <= bus.op;
            r_sub   <= bus.sub;
            r_dec   <= bus.dec & DECIMAL_EN;
            r_a     <= bus.ai;
            r_b     <= bus.bi;
            r_acc   <= '0;
            r_bhi   <= bus.bi[WIDTH-1 -: 2];
            r_carry <= bus.ci;
            r_nz    <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= w_shr ? (r_a << 8) : (r_a >> 8);
            r_b     <= w_shr ? (r_b << 8) : (r_b >> 8);
            r_acc   <= w_acc_nx;
            r_carry <= w_cout;
            r_nz    <= r_nz | (|w_y);
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_out   <= w_acc_nx;
                r_flags <= w_flags;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out       = r_out;
    assign bus.N         = r_flags.n;
    assign bus.V         = r_flags.v;
    assign bus.Z         = r_flags.z;
    assign bus.C         = r_flags.c;

endmodule
